serial_word_shifter: RTL and testbench

Parallel-to-serial front end that feeds the serial pattern-detector stage. Accepts WIDTH-bit words over a valid/ready handshake, buffers one word, and shifts it out one bit per clock on `sout` with a qualifying `sout_valid`. The two-entry buffering (holding register plus shift register) lets back-to-back words stream with no idle bit between them. A saturating gap counter counts stream interruptions.

---
 rtl/serial_word_shifter_if.sv | 14 +
 rtl/serial_word_shifter.sv | 125 ++++++++++++
 tb/tb_serial_word_shifter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/serial_word_shifter_if.sv
// Word input channel of serial_word_shifter: WIDTH-bit parallel words from a producer.
interface serial_word_shifter_if #(
  parameter int WIDTH = 8
);
  // A word transfers on a rising clk edge where din_valid && din_ready. din_ready depends
  // only on the consumer's buffer state, never on din_valid. The producer keeps din stable
  // while din_valid is high and not yet accepted.
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;

  modport master (output din, output din_valid, input din_ready);
  modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/serial_word_shifter.sv
// Parallel-to-serial shifter with one holding register for gapless streaming.
// Build option SER_LSB_FIRST_EN: when defined, words are sent LSB first instead of MSB first.
module serial_word_shifter #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  serial_word_shifter_if.slave  in_if,
  input  logic                  flush,
  output logic                  sout,
  output logic                  sout_valid,
  output logic                  busy,
  output logic [7:0]            gap_cnt,
  output logic                  state_dbg
);
  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] BCNT_LAST = BW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] hold, hold_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic [WIDTH-1:0] sreg_shifted;
  logic             hold_full, hold_full_nxt;
  logic [BW-1:0]    bcnt, bcnt_nxt;
  logic [7:0]       gap_nxt;
  logic             out_bit;
  logic             accept;

`ifdef SER_LSB_FIRST_EN
  assign out_bit      = sreg[0];
  assign sreg_shifted = {1'b0, sreg[WIDTH-1:1]};
`else
  assign out_bit      = sreg[WIDTH-1];
  assign sreg_shifted = {sreg[WIDTH-2:0], 1'b0};
`endif

  assign in_if.din_ready = !hold_full;
  assign accept          = in_if.din_valid && !hold_full;

  // Outputs depend only on registered state, never directly on inputs.
  assign sout_valid = (state == SHIFT);
  assign sout       = (state == SHIFT) ? out_bit : 1'b0;
  assign busy       = (state == SHIFT) || hold_full;
  assign state_dbg  = state;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold      <= '0;
      hold_full <= 1'b0;
      sreg      <= '0;
      bcnt      <= '0;
      gap_cnt   <= 8'd0;
    end else begin
      hold      <= hold_nxt;
      hold_full <= hold_full_nxt;
      sreg      <= sreg_nxt;
      bcnt      <= bcnt_nxt;
      gap_cnt   <= gap_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    hold_nxt      = hold;
    hold_full_nxt = hold_full;
    sreg_nxt      = sreg;
    bcnt_nxt      = bcnt;
    gap_nxt       = gap_cnt;

    // Accept and unload are mutually exclusive: accept needs hold empty, unload needs it full.
    if (accept) begin
      hold_nxt      = in_if.din;
      hold_full_nxt = 1'b1;
    end

    case (state)
      IDLE: begin
        if (hold_full) begin
          sreg_nxt      = hold;
          bcnt_nxt      = BCNT_LAST;
          hold_full_nxt = 1'b0;
          state_nxt     = SHIFT;
        end
      end
      SHIFT: begin
        if (bcnt != '0) begin
          sreg_nxt = sreg_shifted;
          bcnt_nxt = bcnt - 1'b1;
        end else if (hold_full) begin
          sreg_nxt      = hold;
          bcnt_nxt      = BCNT_LAST;
          hold_full_nxt = 1'b0;
        end else begin
          state_nxt = IDLE;
          if (gap_cnt != 8'hFF) begin
            gap_nxt = gap_cnt + 8'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Flush wins over everything, including a same-cycle accept; gap_cnt is left alone.
    if (flush) begin
      hold_full_nxt = 1'b0;
      state_nxt     = IDLE;
      bcnt_nxt      = '0;
      sreg_nxt      = '0;
      gap_nxt       = gap_cnt;
    end
  end
endmodule

// File: tb/tb_serial_word_shifter.sv
// Directed bench for serial_word_shifter (WIDTH=8); define SER_LSB_FIRST_EN for the LSB-first build.
module tb_serial_word_shifter;
  logic       clk;
  logic       rstn;
  logic       flush;
  logic       sout;
  logic       sout_valid;
  logic       busy;
  logic [7:0] gap_cnt;
  logic       state_dbg;

  serial_word_shifter_if #(.WIDTH(8)) bus ();

  serial_word_shifter #(.WIDTH(8)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .in_if      (bus),
    .flush      (flush),
    .sout       (sout),
    .sout_valid (sout_valid),
    .busy       (busy),
    .gap_cnt    (gap_cnt),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [0:0] exp_q[$];
  int         acc_hist[$];
  int         acc_cyc   = 0;
  int         first_cyc = 0;
  int         valid_run = 0;
  int         max_run   = 0;
  int         gap_exp   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // scoreboard: every driven bit is compared in order as the DUT emits it
  always @(negedge clk) begin
    logic [0:0] exp_b;
    if (sout_valid) begin
      if (valid_run == 0) first_cyc = cyc;
      valid_run++;
      if (valid_run > max_run) max_run = valid_run;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL unexpected_bit got=%b exp=none", sout);
      end else begin
        exp_b = exp_q.pop_front();
        assert (sout === exp_b[0]) else begin
          errors++;
          $error("FAIL sout_bit got=%b exp=%b", sout, exp_b[0]);
        end
      end
    end else begin
      valid_run = 0;
      checks++;
      assert (sout === 1'b0) else begin
        errors++;
        $error("FAIL sout_idle got=%b exp=0", sout);
      end
    end
  end

  // driver tasks
  task automatic push_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) begin
`ifdef SER_LSB_FIRST_EN
      exp_q.push_back(w[i]);
`else
      exp_q.push_back(w[7-i]);
`endif
    end
  endtask

  // Called at a falling edge; returns at the falling edge right after the accepting edge.
  task automatic send_word(input logic [7:0] w);
    bit done;
    done = 1'b0;
    bus.din       = w;
    bus.din_valid = 1'b1;
    for (int t = 0; t < 64 && !done; t++) begin
      if (bus.din_ready) begin
        push_word(w);
        done = 1'b1;
      end
      @(negedge clk);
      if (done) begin
        acc_cyc = cyc;
        acc_hist.push_back(cyc);
      end
    end
    bus.din_valid = 1'b0;
    check("send_accepted", {31'd0, done}, 32'd1);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 64 && !done; t++) begin
      @(negedge clk);
      if (!busy && !sout_valid) done = 1'b1;
    end
    check("idle_reached", {31'd0, done}, 32'd1);
    check("queue_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn          = 1'b0;
    flush         = 1'b0;
    bus.din       = 8'h00;
    bus.din_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_sout_valid", {31'd0, sout_valid}, 32'd0);
    check("rst_sout", {31'd0, sout}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_din_ready", {31'd0, bus.din_ready}, 32'd1);
    check("rst_gap_cnt", {24'd0, gap_cnt}, 32'd0);
    check("rst_state", {31'd0, state_dbg}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // single word
    max_run = 0;
    send_word(8'hD4);
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    wait_idle();
    gap_exp++;
    // acc_cyc is edge E, first_cyc is the edge that starts the first valid bit (E+1)
    check("single_latency", first_cyc - acc_cyc, 32'd1);
    check("single_run", max_run, 32'd8);
    check("single_gap", {24'd0, gap_cnt}, gap_exp);

    // back-to-back
    max_run = 0;
    send_word(8'hA5);
    send_word(8'h3C);
    wait_idle();
    gap_exp++;
    check("b2b_run", max_run, 32'd16);
    check("b2b_gap", {24'd0, gap_cnt}, gap_exp);

    // backpressure: din_valid held continuously across four words
    max_run = 0;
    acc_hist.delete();
    send_word(8'h96);
    send_word(8'h5A);
    send_word(8'hC3);
    send_word(8'h7E);
    wait_idle();
    gap_exp++;
    check("bp_acc_12", acc_hist[1] - acc_hist[0], 32'd2);
    check("bp_acc_23", acc_hist[2] - acc_hist[1], 32'd8);
    check("bp_acc_34", acc_hist[3] - acc_hist[2], 32'd8);
    check("bp_run", max_run, 32'd32);
    check("bp_gap", {24'd0, gap_cnt}, gap_exp);

    // flush mid-word with a second word waiting in hold
    max_run = 0;
    send_word(8'hFF);
    send_word(8'h0F);
    check("flush_hold_full", {31'd0, bus.din_ready}, 32'd0);
    @(negedge clk);
    #1;
    flush = 1'b1;
    exp_q.delete();
    @(negedge clk);
    flush = 1'b0;
    check("flush_valid", {31'd0, sout_valid}, 32'd0);
    check("flush_ready", {31'd0, bus.din_ready}, 32'd1);
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_gap", {24'd0, gap_cnt}, gap_exp);
    check("flush_bits_out", max_run, 32'd3);
    repeat (12) @(negedge clk);
    check("flush_quiet", {31'd0, sout_valid}, 32'd0);
    check("flush_gap_after", {24'd0, gap_cnt}, gap_exp);

    // asynchronous reset mid-stream
    send_word(8'h5A);
    repeat (2) @(negedge clk);
    #2;
    rstn = 1'b0;
    exp_q.delete();
    gap_exp = 0;
    #1;
    check("arst_valid", {31'd0, sout_valid}, 32'd0);
    check("arst_sout", {31'd0, sout}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_gap", {24'd0, gap_cnt}, 32'd0);
    check("arst_ready", {31'd0, bus.din_ready}, 32'd1);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    max_run = 0;
    send_word(8'h81);
    wait_idle();
    gap_exp++;
    check("arst_word_run", max_run, 32'd8);
    check("arst_word_gap", {24'd0, gap_cnt}, gap_exp);

    // saturation of the gap counter with random isolated words
    for (int i = 0; i < 300; i++) begin
      send_word(8'($urandom_range(0, 255)));
      wait_idle();
      if (gap_exp < 255) gap_exp++;
      check("sat_gap", {24'd0, gap_cnt}, gap_exp);
    end
    check("sat_final", {24'd0, gap_cnt}, 32'd255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
